hbridge_drive_sequencer: RTL and testbench

APB3 slave that sequences both H-bridge motor channels of the car: it accepts per-side speed/direction commands from the MSS, ramps the applied PWM duty toward each target once per PWM period, inserts a forced-idle dead time on every direction reversal, and stops both motors if software stops refreshing commands. It sits on a CoreAPB3 slave slot, is clocked by the MSS fabric clock with the MSS fabric reset, and drives LEFT_HB1/2 and RIGHT_HB1/2 directly.

---
 rtl/hbridge_drive_sequencer.sv | 219 +++++++++++++++++++++
 tb/tb_hbridge_drive_sequencer.sv | 350 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/hbridge_drive_sequencer.sv
// APB3 dual H-bridge sequencer: per-side duty ramping once per PWM period, forced dead time
// on direction reversal, and a command watchdog that ramps both motors down when it expires.
module hbridge_drive_sequencer #(
   parameter int PWM_BITS = 10,
   parameter int DEADTIME = 64,
   parameter int WDT_BITS = 24
) (
   input  logic        PCLK,
   input  logic        PRESERN,
   input  logic        PSEL,
   input  logic        PENABLE,
   input  logic        PWRITE,
   input  logic [31:0] PADDR,
   input  logic [31:0] PWDATA,
   output logic [31:0] PRDATA,
   output logic        PREADY,
   output logic        PSLVERR,
   output logic        LEFT_HB1,
   output logic        LEFT_HB2,
   output logic        RIGHT_HB1,
   output logic        RIGHT_HB2
);
   localparam logic [1:0] ST_IDLE  = 2'd0;
   localparam logic [1:0] ST_DRIVE = 2'd1;
   localparam logic [1:0] ST_DEAD  = 2'd2;
   localparam int DW = $clog2(DEADTIME + 1);
   localparam int CW = PWM_BITS + 8;
   localparam logic [DW-1:0] DEAD_LOAD = DW'(DEADTIME);

   // Register file
   logic [PWM_BITS:0]   cmd_q [2];
   logic [PWM_BITS:0]   cmd_d [2];
   logic                en_q, en_d;
   logic [7:0]          step_q, step_d;
   logic [WDT_BITS-1:0] reload_q, reload_d;
   logic [WDT_BITS-1:0] wdt_q, wdt_d;
   logic                exp_q, exp_d;

   // PWM timebase and per-channel sequencing (index 0 = left, 1 = right)
   logic [PWM_BITS-1:0] pwm_cnt_q, pwm_cnt_d;
   logic [1:0]          state_q [2];
   logic [1:0]          state_d [2];
   logic                cur_dir_q [2];
   logic                cur_dir_d [2];
   logic [PWM_BITS-1:0] cur_duty_q [2];
   logic [PWM_BITS-1:0] cur_duty_d [2];
   logic [DW-1:0]       dead_cnt_q [2];
   logic [DW-1:0]       dead_cnt_d [2];
   logic                hb1_q [2];
   logic                hb1_d [2];
   logic                hb2_q [2];
   logic                hb2_d [2];

   logic [2:0] reg_idx;
   logic       addr_ok;
   logic       wr_en;
   logic       wdt_kick;
   logic       boundary;
   logic       unused_ok;

   assign reg_idx   = PADDR[4:2];
   assign addr_ok   = (reg_idx <= 3'd4);
   assign wr_en     = PSEL & PENABLE & PWRITE & addr_ok;
   assign wdt_kick  = wr_en & ((reg_idx == 3'd0) | (reg_idx == 3'd1) | (reg_idx == 3'd3));
   assign boundary  = &pwm_cnt_q;
   assign PREADY    = 1'b1;
   assign PSLVERR   = PSEL & PENABLE & ~addr_ok;
   assign unused_ok = ^{PADDR[31:5], PADDR[1:0], PWDATA};

   assign LEFT_HB1  = hb1_q[0];
   assign LEFT_HB2  = hb2_q[0];
   assign RIGHT_HB1 = hb1_q[1];
   assign RIGHT_HB2 = hb2_q[1];

   // One ramp step toward tgt; clamps onto tgt when within reach so it never overshoots or wraps.
   function automatic logic [PWM_BITS-1:0] ramp_step(
      input logic [PWM_BITS-1:0] cur,
      input logic [PWM_BITS-1:0] tgt,
      input logic [7:0]          step
   );
      logic [CW-1:0] diff;
      logic [CW-1:0] step_w;
      step_w = CW'(step);
      diff   = (tgt > cur) ? CW'(tgt - cur) : CW'(cur - tgt);
      if (step == 8'd0 || diff <= step_w) return tgt;
      else if (tgt > cur) return cur + PWM_BITS'(step);
      else return cur - PWM_BITS'(step);
   endfunction

   always_comb begin
      PRDATA = '0;
      if (PSEL && addr_ok) begin
         case (reg_idx)
            3'd0:    PRDATA = 32'(cmd_q[0]);
            3'd1:    PRDATA = 32'(cmd_q[1]);
            3'd2:    PRDATA = {16'd0, step_q, 7'd0, en_q};
            3'd3:    PRDATA = 32'(reload_q);
            3'd4:    PRDATA = {29'd0, state_q[1] == ST_DEAD, state_q[0] == ST_DEAD, exp_q};
            default: PRDATA = '0;
         endcase
      end
   end

   always_comb begin
      cmd_d    = cmd_q;
      en_d     = en_q;
      step_d   = step_q;
      reload_d = reload_q;
      wdt_d    = wdt_q;
      exp_d    = exp_q;
      if (wr_en) begin
         case (reg_idx)
            3'd0: cmd_d[0] = {PWDATA[PWM_BITS], (exp_q ? {PWM_BITS{1'b0}} : PWDATA[PWM_BITS-1:0])};
            3'd1: cmd_d[1] = {PWDATA[PWM_BITS], (exp_q ? {PWM_BITS{1'b0}} : PWDATA[PWM_BITS-1:0])};
            3'd2: begin
               en_d   = PWDATA[0];
               step_d = PWDATA[15:8];
            end
            3'd3: reload_d = PWDATA[WDT_BITS-1:0];
            3'd4: if (PWDATA[0]) exp_d = 1'b0;
            default: ;
         endcase
      end
      // Counter parks at 0 after expiry, so a cleared WDT_EXP stays clear until the next kick.
      if (wdt_kick) begin
         wdt_d = reload_d;
      end else if (reload_q != '0 && wdt_q != '0) begin
         wdt_d = wdt_q - WDT_BITS'(1);
         if (wdt_q == WDT_BITS'(1)) begin
            exp_d                    = 1'b1;
            cmd_d[0][PWM_BITS-1:0]   = '0;
            cmd_d[1][PWM_BITS-1:0]   = '0;
         end
      end
   end

   always_comb begin
      pwm_cnt_d = pwm_cnt_q + PWM_BITS'(1);
      for (int unsigned ch = 0; ch < 2; ch++) begin
         state_d[ch]    = state_q[ch];
         cur_dir_d[ch]  = cur_dir_q[ch];
         cur_duty_d[ch] = cur_duty_q[ch];
         dead_cnt_d[ch] = dead_cnt_q[ch];
         hb1_d[ch]      = 1'b0;
         hb2_d[ch]      = 1'b0;
         if (!en_q) begin
            state_d[ch]    = ST_IDLE;
            cur_duty_d[ch] = '0;
            dead_cnt_d[ch] = '0;
         end else begin
            case (state_q[ch])
               ST_IDLE: begin
                  state_d[ch]    = ST_DRIVE;
                  cur_dir_d[ch]  = cmd_q[ch][PWM_BITS];
                  cur_duty_d[ch] = '0;
               end
               ST_DRIVE: begin
                  if (boundary) begin
                     if (cur_duty_q[ch] == '0 && cmd_q[ch][PWM_BITS] != cur_dir_q[ch]) begin
                        state_d[ch]    = ST_DEAD;
                        dead_cnt_d[ch] = DEAD_LOAD;
                     end else begin
                        cur_duty_d[ch] = ramp_step(cur_duty_q[ch],
                           (cmd_q[ch][PWM_BITS] == cur_dir_q[ch]) ? cmd_q[ch][PWM_BITS-1:0] : '0,
                           step_q);
                     end
                  end
               end
               ST_DEAD: begin
                  if (dead_cnt_q[ch] <= DW'(1)) begin
                     state_d[ch]    = ST_DRIVE;
                     cur_dir_d[ch]  = cmd_q[ch][PWM_BITS];
                     dead_cnt_d[ch] = '0;
                  end else begin
                     dead_cnt_d[ch] = dead_cnt_q[ch] - DW'(1);
                  end
               end
               default: state_d[ch] = ST_IDLE;
            endcase
            if (state_q[ch] == ST_DRIVE && pwm_cnt_q < cur_duty_q[ch]) begin
               hb1_d[ch] = ~cur_dir_q[ch];
               hb2_d[ch] = cur_dir_q[ch];
            end
         end
      end
   end

   always_ff @(posedge PCLK or negedge PRESERN) begin
      if (!PRESERN) begin
         cmd_q      <= '{default: '0};
         en_q       <= 1'b0;
         step_q     <= '0;
         reload_q   <= '0;
         wdt_q      <= '0;
         exp_q      <= 1'b0;
         pwm_cnt_q  <= '0;
         state_q    <= '{default: ST_IDLE};
         cur_dir_q  <= '{default: 1'b0};
         cur_duty_q <= '{default: '0};
         dead_cnt_q <= '{default: '0};
         hb1_q      <= '{default: 1'b0};
         hb2_q      <= '{default: 1'b0};
      end else begin
         cmd_q      <= cmd_d;
         en_q       <= en_d;
         step_q     <= step_d;
         reload_q   <= reload_d;
         wdt_q      <= wdt_d;
         exp_q      <= exp_d;
         pwm_cnt_q  <= pwm_cnt_d;
         state_q    <= state_d;
         cur_dir_q  <= cur_dir_d;
         cur_duty_q <= cur_duty_d;
         dead_cnt_q <= dead_cnt_d;
         hb1_q      <= hb1_d;
         hb2_q      <= hb2_d;
      end
   end
endmodule

// File: tb/tb_hbridge_drive_sequencer.sv
// Bench for hbridge_drive_sequencer: per-period high-time expectations are queued with the
// stimulus and compared when each PWM period window completes.
module tb_hbridge_drive_sequencer;
   localparam int PERIOD = 1024;
   localparam logic [31:0] A_LEFT = 32'h00, A_RIGHT = 32'h04, A_CTRL = 32'h08;
   localparam logic [31:0] A_WDT = 32'h0C, A_STAT = 32'h10, A_BAD = 32'h14;

   logic        PCLK = 1'b0;
   logic        PRESERN = 1'b0;
   logic        PSEL = 1'b0, PENABLE = 1'b0, PWRITE = 1'b0;
   logic [31:0] PADDR = '0, PWDATA = '0;
   logic [31:0] PRDATA;
   logic        PREADY, PSLVERR;
   logic        LEFT_HB1, LEFT_HB2, RIGHT_HB1, RIGHT_HB2;

   typedef struct { int l1; int l2; int r1; int r2; } per_t;
   per_t sbq[$];

   int vectors = 0;
   int miscompares = 0;
   int cyc;
   int wr_cyc;
   bit active = 0;
   int acc_l1, acc_l2, acc_r1, acc_r2;
   int overlap = 0;
   bit poll_status = 0;
   int dead_seen = 0;

   hbridge_drive_sequencer #(.PWM_BITS(10), .DEADTIME(64), .WDT_BITS(24)) dut (
      .PCLK(PCLK), .PRESERN(PRESERN), .PSEL(PSEL), .PENABLE(PENABLE), .PWRITE(PWRITE),
      .PADDR(PADDR), .PWDATA(PWDATA), .PRDATA(PRDATA), .PREADY(PREADY), .PSLVERR(PSLVERR),
      .LEFT_HB1(LEFT_HB1), .LEFT_HB2(LEFT_HB2), .RIGHT_HB1(RIGHT_HB1), .RIGHT_HB2(RIGHT_HB2)
   );

   always #5 PCLK = ~PCLK;

   // Mirrors the free-running PWM counter: edges since reset release.
   always @(posedge PCLK or negedge PRESERN)
      if (!PRESERN) cyc <= 0;
      else cyc <= cyc + 1;

   always @(negedge PCLK) begin
      per_t e;
      if (!PRESERN) begin
         active = 0;
      end else begin
         if (cyc % PERIOD == 1) begin
            active = (sbq.size() != 0);
            acc_l1 = 0; acc_l2 = 0; acc_r1 = 0; acc_r2 = 0;
         end
         acc_l1 += int'(LEFT_HB1);
         acc_l2 += int'(LEFT_HB2);
         acc_r1 += int'(RIGHT_HB1);
         acc_r2 += int'(RIGHT_HB2);
         if ((LEFT_HB1 && LEFT_HB2) || (RIGHT_HB1 && RIGHT_HB2)) overlap++;
         if (poll_status && PRDATA[1]) dead_seen++;
         if (cyc % PERIOD == 0 && active) begin
            e = sbq.pop_front();
            active = 0;
            vectors++;
            if (acc_l1 !== e.l1 || acc_l2 !== e.l2 || acc_r1 !== e.r1 || acc_r2 !== e.r2) begin
               miscompares++;
               $display("FAIL period_high_time at cyc %0d: got L1/L2/R1/R2 %0d/%0d/%0d/%0d, expected %0d/%0d/%0d/%0d",
                        cyc, acc_l1, acc_l2, acc_r1, acc_r2, e.l1, e.l2, e.r1, e.r2);
            end
         end
      end
   end

   task automatic do_reset();
      PRESERN = 1'b0;
      PSEL = 1'b0; PENABLE = 1'b0; PWRITE = 1'b0; PADDR = '0; PWDATA = '0;
      repeat (3) @(negedge PCLK);
      PRESERN = 1'b1;
   endtask

   task automatic apb_write(input logic [31:0] a, input logic [31:0] d, output logic err);
      @(posedge PCLK); #1;
      PSEL = 1'b1; PENABLE = 1'b0; PWRITE = 1'b1; PADDR = a; PWDATA = d;
      @(posedge PCLK); #1;
      PENABLE = 1'b1;
      #3 err = PSLVERR;
      @(posedge PCLK); #1;
      wr_cyc = cyc;
      PSEL = 1'b0; PENABLE = 1'b0; PWRITE = 1'b0;
   endtask

   task automatic apb_read(input logic [31:0] a, output logic [31:0] d, output logic err);
      @(posedge PCLK); #1;
      PSEL = 1'b1; PENABLE = 1'b0; PWRITE = 1'b0; PADDR = a;
      @(posedge PCLK); #1;
      PENABLE = 1'b1;
      #3 begin d = PRDATA; err = PSLVERR; end
      @(posedge PCLK); #1;
      PSEL = 1'b0; PENABLE = 1'b0;
   endtask

   task automatic align_period();
      @(negedge PCLK);
      while (cyc % PERIOD != 0) @(negedge PCLK);
      #2;
   endtask

   task automatic wait_sb(input string name);
      int n = 0;
      while (sbq.size() != 0 && n < 8 * PERIOD) begin
         @(negedge PCLK);
         n++;
      end
      if (sbq.size() != 0) begin
         vectors++;
         miscompares++;
         $display("FAIL %s scoreboard timeout: %0d periods still expected, required 0", name, sbq.size());
         sbq.delete();
      end
   endtask

   task automatic test_reset();
      logic [31:0] d;
      logic err;
      do_reset();
      #1;
      vectors++;
      if ({LEFT_HB1, LEFT_HB2, RIGHT_HB1, RIGHT_HB2} !== 4'b0000) begin
         miscompares++;
         $display("FAIL reset_hb got %b required 0000", {LEFT_HB1, LEFT_HB2, RIGHT_HB1, RIGHT_HB2});
      end
      vectors++;
      if ({PREADY, PSLVERR} !== 2'b10) begin
         miscompares++;
         $display("FAIL reset_pready_pslverr got %b required 10", {PREADY, PSLVERR});
      end
      vectors++;
      if (PRDATA !== 32'h0) begin
         miscompares++;
         $display("FAIL reset_prdata_idle got %h required 0", PRDATA);
      end
      for (int i = 0; i < 5; i++) begin
         apb_read(32'(i * 4), d, err);
         vectors++;
         if (d !== 32'h0 || err !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_read_%0h got data %h err %b required 0/0", i * 4, d, err);
         end
      end
   endtask

   task automatic test_left_forward();
      logic err;
      do_reset();
      apb_write(A_CTRL, 32'h0001, err);
      apb_write(A_LEFT, 32'd256, err);
      align_period();
      sbq.push_back(per_t'{256, 0, 0, 0});
      sbq.push_back(per_t'{256, 0, 0, 0});
      wait_sb("left_forward");
   endtask

   task automatic test_reversal();
      logic [31:0] d;
      logic err;
      align_period();
      sbq.push_back(per_t'{256, 0, 0, 0});
      sbq.push_back(per_t'{0, 0, 0, 0});
      sbq.push_back(per_t'{0, 0, 0, 0});
      sbq.push_back(per_t'{0, 128, 0, 0});
      sbq.push_back(per_t'{0, 128, 0, 0});
      apb_write(A_LEFT, 32'h480, err);
      PSEL = 1'b1; PWRITE = 1'b0; PENABLE = 1'b0; PADDR = A_STAT;
      dead_seen = 0;
      poll_status = 1;
      wait_sb("reversal");
      poll_status = 0;
      PSEL = 1'b0;
      vectors++;
      if (dead_seen !== 64) begin
         miscompares++;
         $display("FAIL reversal_dead_cycles got %0d required 64", dead_seen);
      end
      apb_read(A_LEFT, d, err);
      vectors++;
      if (d !== 32'h480) begin
         miscompares++;
         $display("FAIL reversal_cmd_readback got %h required 480", d);
      end
   endtask

   task automatic test_ramp();
      logic err;
      do_reset();
      apb_write(A_CTRL, 32'h4001, err);
      apb_write(A_RIGHT, 32'd256, err);
      align_period();
      sbq.push_back(per_t'{0, 0, 64, 0});
      sbq.push_back(per_t'{0, 0, 128, 0});
      sbq.push_back(per_t'{0, 0, 192, 0});
      sbq.push_back(per_t'{0, 0, 256, 0});
      sbq.push_back(per_t'{0, 0, 256, 0});
      wait_sb("ramp_up");
      align_period();
      sbq.push_back(per_t'{0, 0, 256, 0});
      sbq.push_back(per_t'{0, 0, 192, 0});
      sbq.push_back(per_t'{0, 0, 128, 0});
      sbq.push_back(per_t'{0, 0, 100, 0});
      sbq.push_back(per_t'{0, 0, 100, 0});
      apb_write(A_RIGHT, 32'd100, err);
      wait_sb("ramp_down");
   endtask

   task automatic test_watchdog();
      logic [31:0] d;
      logic err;
      int n;
      int e_cyc;
      do_reset();
      apb_write(A_CTRL, 32'h0001, err);
      apb_write(A_WDT, 32'd5000, err);
      apb_write(A_LEFT, 32'd300, err);
      e_cyc = wr_cyc;
      align_period();
      sbq.push_back(per_t'{300, 0, 0, 0});
      wait_sb("wdt_before_expiry");
      @(posedge PCLK); #1;
      PSEL = 1'b1; PWRITE = 1'b0; PENABLE = 1'b0; PADDR = A_STAT;
      n = 0;
      while (PRDATA[0] !== 1'b1 && n < 6000) begin
         @(negedge PCLK);
         n++;
      end
      vectors++;
      if (cyc - e_cyc !== 5000) begin
         miscompares++;
         $display("FAIL wdt_expiry_delay got %0d cycles required 5000", cyc - e_cyc);
      end
      vectors++;
      if (PRDATA !== 32'h1) begin
         miscompares++;
         $display("FAIL wdt_status_value got %h required 1", PRDATA);
      end
      PSEL = 1'b0;
      align_period();
      sbq.push_back(per_t'{0, 0, 0, 0});
      wait_sb("wdt_outputs_low");
      apb_write(A_LEFT, 32'h0FF, err);
      apb_read(A_LEFT, d, err);
      vectors++;
      if (d !== 32'h0) begin
         miscompares++;
         $display("FAIL wdt_cmd_duty_blocked got %h required 0", d);
      end
      apb_write(A_STAT, 32'h1, err);
      apb_read(A_STAT, d, err);
      vectors++;
      if (d !== 32'h0) begin
         miscompares++;
         $display("FAIL wdt_w1c got %h required 0", d);
      end
      apb_write(A_LEFT, 32'd200, err);
      align_period();
      sbq.push_back(per_t'{200, 0, 0, 0});
      wait_sb("wdt_restore");
   endtask

   task automatic test_slverr();
      logic [31:0] d;
      logic err;
      do_reset();
      apb_write(A_CTRL, 32'h4001, err);
      apb_write(A_LEFT, 32'h123, err);
      vectors++;
      if (err !== 1'b0) begin
         miscompares++;
         $display("FAIL valid_write_pslverr got %b required 0", err);
      end
      apb_write(A_BAD, 32'hFFFF_FFFF, err);
      vectors++;
      if (err !== 1'b1) begin
         miscompares++;
         $display("FAIL bad_write_pslverr got %b required 1", err);
      end
      apb_read(A_BAD, d, err);
      vectors++;
      if (d !== 32'h0 || err !== 1'b1) begin
         miscompares++;
         $display("FAIL bad_read got data %h err %b required 0/1", d, err);
      end
      apb_read(A_CTRL, d, err);
      vectors++;
      if (d !== 32'h4001 || err !== 1'b0) begin
         miscompares++;
         $display("FAIL bad_write_ctrl_intact got %h err %b required 4001/0", d, err);
      end
      apb_read(A_LEFT, d, err);
      vectors++;
      if (d !== 32'h123) begin
         miscompares++;
         $display("FAIL bad_write_left_intact got %h required 123", d);
      end
      apb_read(A_WDT, d, err);
      vectors++;
      if (d !== 32'h0) begin
         miscompares++;
         $display("FAIL bad_write_wdt_intact got %h required 0", d);
      end
      apb_read(A_STAT, d, err);
      vectors++;
      if (d !== 32'h0) begin
         miscompares++;
         $display("FAIL bad_write_status_intact got %h required 0", d);
      end
   endtask

   task automatic test_async_reset();
      int n = 0;
      while (LEFT_HB1 !== 1'b1 && n < 3 * PERIOD) begin
         @(negedge PCLK);
         n++;
      end
      if (LEFT_HB1 !== 1'b1) begin
         vectors++;
         miscompares++;
         $display("FAIL async_reset_precondition LEFT_HB1 got %b required 1", LEFT_HB1);
      end
      #2 PRESERN = 1'b0;
      #1;
      vectors++;
      if ({LEFT_HB1, LEFT_HB2, RIGHT_HB1, RIGHT_HB2} !== 4'b0000) begin
         miscompares++;
         $display("FAIL async_reset_hb got %b required 0000", {LEFT_HB1, LEFT_HB2, RIGHT_HB1, RIGHT_HB2});
      end
      do_reset();
   endtask

   initial begin
      test_reset();
      test_left_forward();
      test_reversal();
      test_ramp();
      test_watchdog();
      test_slverr();
      test_async_reset();
      vectors++;
      if (overlap !== 0) begin
         miscompares++;
         $display("FAIL hb1_hb2_overlap got %0d cycles required 0", overlap);
      end
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end
endmodule
